// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet conv/pool datapath.
//   PIXEL_W           : pixel width in bits
//   pixel_t           : signed pixel type
//   streamer_state_t  : pixel streamer FSM states
//   width_for()       : counter width able to hold 0..maxval, never below 1
package lenet_pkg;

    localparam int unsigned PIXEL_W = 8;

    typedef logic signed [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        WAIT_DONE
    } streamer_state_t;

    function automatic int unsigned width_for(input int unsigned maxval);
        return (maxval == 0) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/lenet_rate_gap.sv
// Throttle counter for the pixel streamer.
// Loads GAP_CYCLES when a read is issued, otherwise counts down to 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force counter to 0 (start of a frame)
//   load       : a read was issued this cycle; reload GAP_CYCLES
//   zero       : counter is 0, a new read may be issued
module lenet_rate_gap
    import lenet_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    output logic zero
);

    localparam int unsigned CNT_W = width_for(GAP_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(GAP_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lenet_pixel_streamer.sv
// Source end of the conv/pool pixel stream. Reads one MAPSIZE x MAPSIZE frame
// from a synchronous-read frame RAM in raster order, forwards it to the layer
// top as start / valid / pixel, then waits for layer_done under a watchdog.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   go             : one-cycle request to stream a frame (ignored while busy)
//   pause          : level; holds off new frame reads
//   frame_rd_en    : frame RAM read strobe
//   frame_rd_addr  : frame RAM address, 0..NPIX-1
//   frame_rd_data  : pixel returned one cycle after frame_rd_en
//   net_start      : one-cycle start pulse to the layer top
//   net_valid      : pixel strobe to the layer top
//   net_pixel      : pixel to the layer top (0 when not valid)
//   layer_done     : completion from the layer top
//   busy           : high from accepted go until back in IDLE
//   done           : one-cycle pulse on clean completion
//   timeout_err    : sticky watchdog error, cleared by the next accepted go
module lenet_pixel_streamer
    import lenet_pkg::*;
#(
    parameter  int unsigned MAPSIZE    = 32,
    parameter  int unsigned GAP_CYCLES = 0,
    parameter  int unsigned TIMEOUT    = 65535,
    localparam int unsigned NPIX       = MAPSIZE * MAPSIZE,
    localparam int unsigned ADDR_W     = $clog2(NPIX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic              pause,
    output logic              frame_rd_en,
    output logic [ADDR_W-1:0] frame_rd_addr,
    input  pixel_t            frame_rd_data,
    output logic              net_start,
    output logic              net_valid,
    output pixel_t            net_pixel,
    input  logic              layer_done,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int unsigned WD_W = width_for(TIMEOUT);

    streamer_state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [WD_W-1:0]   wd_q;
    logic              gap_zero;
    logic              issue;
    logic              last_issue;
    logic              finish_ok;
    logic              finish_to;
    logic              accept_go;
    logic              valid_q;
    logic              done_q;
    logic              te_q;

    lenet_rate_gap #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == START),
        .load  (issue),
        .zero  (gap_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        last_issue = 1'b0;
        finish_ok  = 1'b0;
        finish_to  = 1'b0;
        accept_go  = 1'b0;
        net_start  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (go) begin
                    accept_go = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                net_start = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                issue      = !pause && gap_zero;
                last_issue = issue && (addr_q == ADDR_W'(NPIX - 1));
                if (last_issue) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // layer_done wins over a watchdog expiring in the same cycle
                if (layer_done) begin
                    finish_ok = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_q >= WD_W'(TIMEOUT - 1)) begin
                    finish_to = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address holds at NPIX-1 after the last read so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (state == START) begin
            addr_q <= '0;
        end else if (issue && !last_issue) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    // Watchdog counts WAIT_DONE cycles from entry and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state != WAIT_DONE) begin
            wd_q <= '0;
        end else if (wd_q != '1) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            te_q    <= 1'b0;
        end else begin
            valid_q <= issue;
            done_q  <= finish_ok;
            if (accept_go) begin
                te_q <= 1'b0;
            end else if (finish_to) begin
                te_q <= 1'b1;
            end
        end
    end

    // RAM data arrives in the cycle after the read, aligned with valid_q.
    assign frame_rd_en   = issue;
    assign frame_rd_addr = addr_q;
    assign net_valid     = valid_q;
    assign net_pixel     = valid_q ? frame_rd_data : '0;
    assign done          = done_q;
    assign timeout_err   = te_q;

endmodule

// File: tb/tb_lenet_pixel_streamer.sv
module tb_lenet_pixel_streamer;
    import lenet_pkg::*;

    localparam int unsigned MAP  = 32;
    localparam int          NPIX = 1024;
    localparam int unsigned TMO  = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT with no throttle
    logic       go0, pause0, rd_en0, net_start0, net_valid0, layer_done0, busy0, done0, te0;
    logic [9:0] rd_addr0;
    pixel_t     rd_data0, net_pixel0;
    pixel_t     mem0 [NPIX];

    // DUT with GAP_CYCLES = 2
    logic       go2, pause2, rd_en2, net_start2, net_valid2, layer_done2, busy2, done2, te2;
    logic [9:0] rd_addr2;
    pixel_t     rd_data2, net_pixel2;
    pixel_t     mem2 [NPIX];

    lenet_pixel_streamer #(.MAPSIZE(MAP), .GAP_CYCLES(0), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst_n(rst_n), .go(go0), .pause(pause0),
        .frame_rd_en(rd_en0), .frame_rd_addr(rd_addr0), .frame_rd_data(rd_data0),
        .net_start(net_start0), .net_valid(net_valid0), .net_pixel(net_pixel0),
        .layer_done(layer_done0), .busy(busy0), .done(done0), .timeout_err(te0)
    );

    lenet_pixel_streamer #(.MAPSIZE(MAP), .GAP_CYCLES(2), .TIMEOUT(TMO)) dut2 (
        .clk(clk), .rst_n(rst_n), .go(go2), .pause(pause2),
        .frame_rd_en(rd_en2), .frame_rd_addr(rd_addr2), .frame_rd_data(rd_data2),
        .net_start(net_start2), .net_valid(net_valid2), .net_pixel(net_pixel2),
        .layer_done(layer_done2), .busy(busy2), .done(done2), .timeout_err(te2)
    );

    // Synchronous-read frame RAMs
    always @(posedge clk) if (rd_en0) rd_data0 <= mem0[rd_addr0];
    always @(posedge clk) if (rd_en2) rd_data2 <= mem2[rd_addr2];

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Frame scenario: expected stream is the RAM contents in raster order;
    // expected timing follows from go time, pause window and layer_done time.
    typedef struct {
        bit ramp;
        int pause_at;    // -1: no pause
        int pause_len;
        bit go_mid;      // extra go while streaming
        bit ld_mid;      // layer_done pulse while streaming
        int done_delay;  // cycles after last beat; -1: never
        int exp_done;
        int exp_te;
        int exp_fall;    // busy-low cycle minus last-beat cycle
    } scen_t;

    scen_t tbl [6];

    task automatic run_frame(input scen_t s, input int idx, input int prev_te);
        int t0, c, nbeats, starts, start_cyc, dones, done_busy, fall, last_beat;
        int pause_left, mism, first_addr, te_start, busy_start, span, exp_span;
        int beat_cyc [NPIX];
        for (int i = 0; i < NPIX; i++)
            mem0[i] = s.ramp ? pixel_t'(i % 128) : pixel_t'($urandom);
        check("te_sticky_before_go", idx, int'(te0), prev_te);
        nbeats = 0; starts = 0; start_cyc = -1; dones = 0; done_busy = -1; fall = -1;
        last_beat = -1; pause_left = 0; mism = 0; first_addr = -1; te_start = -1; busy_start = -1;
        @(posedge clk); #1;
        go0 = 1'b1;
        t0  = cyc;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            c = cyc;
            if (c == t0 + 1) begin
                te_start   = int'(te0);
                busy_start = int'(busy0);
            end
            if (net_start0) begin
                starts++;
                if (start_cyc < 0) start_cyc = c;
            end
            if (rd_en0 && first_addr < 0) first_addr = int'(rd_addr0);
            if (net_valid0) begin
                if (nbeats < NPIX) begin
                    beat_cyc[nbeats] = c;
                    if (net_pixel0 !== mem0[nbeats]) mism++;
                end
                nbeats++;
                if (nbeats == NPIX) last_beat = c;
            end
            if (done0) begin
                dones++;
                done_busy = int'(busy0);
            end
            if (fall < 0 && c > t0 && !busy0) fall = c;
            if (s.pause_at >= 0 && rd_en0 && int'(rd_addr0) == s.pause_at) pause_left = s.pause_len;
            if (fall >= 0 && c >= fall + 3) break;
            @(posedge clk); #1;
            go0    = s.go_mid && (c + 1 == t0 + 200);
            pause0 = (pause_left > 0);
            if (pause_left > 0) pause_left--;
            layer_done0 = (s.ld_mid && (c + 1 == t0 + 300)) ||
                          (s.done_delay >= 0 && last_beat >= 0 && (c + 1 == last_beat + s.done_delay));
        end
        go0 = 1'b0; pause0 = 1'b0; layer_done0 = 1'b0;

        check("start_count", idx, starts, 1);
        check("start_cycle", idx, start_cyc - t0, 1);
        check("busy_in_start", idx, busy_start, 1);
        check("te_cleared_by_go", idx, te_start, 0);
        check("first_rd_addr", idx, first_addr, 0);
        check("beat_count", idx, nbeats, NPIX);
        check("data_mismatches", idx, mism, 0);
        check("first_beat_latency", idx, (nbeats > 0) ? beat_cyc[0] - t0 : -1, 3);
        exp_span = NPIX - 1 + ((s.pause_at >= 0) ? s.pause_len : 0);
        span = (nbeats >= NPIX) ? beat_cyc[NPIX-1] - beat_cyc[0] : -1;
        check("beat_span", idx, span, exp_span);
        if (s.pause_at >= 0)
            check("pause_gap", idx,
                  (nbeats > s.pause_at + 1) ? beat_cyc[s.pause_at+1] - beat_cyc[s.pause_at] : -1,
                  s.pause_len + 1);
        check("done_count", idx, dones, s.exp_done);
        if (s.exp_done != 0) check("busy_low_with_done", idx, done_busy, 0);
        check("busy_fall_offset", idx, (fall >= 0 && last_beat >= 0) ? fall - last_beat : -1, s.exp_fall);
        check("timeout_err", idx, int'(te0), s.exp_te);
    endtask

    task automatic run_gap_frame();
        int t0, c, nbeats, mism, bad_gap, prev, first, last, dones, fall;
        for (int i = 0; i < NPIX; i++) mem2[i] = pixel_t'($urandom);
        nbeats = 0; mism = 0; bad_gap = 0; prev = -1; first = -1; last = -1; dones = 0; fall = -1;
        @(posedge clk); #1;
        go2 = 1'b1;
        t0  = cyc;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            c = cyc;
            if (net_valid2) begin
                if (nbeats < NPIX && net_pixel2 !== mem2[nbeats]) mism++;
                if (prev >= 0 && c - prev != 3) bad_gap++;
                if (first < 0) first = c;
                prev = c;
                nbeats++;
                if (nbeats == NPIX) last = c;
            end
            if (done2) dones++;
            if (fall < 0 && c > t0 && !busy2) fall = c;
            if (fall >= 0 && c >= fall + 3) break;
            @(posedge clk); #1;
            go2         = 1'b0;
            layer_done2 = (last >= 0 && c + 1 == last + 2);
        end
        go2 = 1'b0; layer_done2 = 1'b0;
        check("gap_beat_count", 0, nbeats, NPIX);
        check("gap_data_mismatches", 0, mism, 0);
        check("gap_bad_spacing", 0, bad_gap, 0);
        check("gap_first_beat_latency", 0, (first >= 0) ? first - t0 : -1, 3);
        check("gap_span", 0, (first >= 0 && last >= 0) ? last - first : -1, 3 * (NPIX - 1));
        check("gap_done_count", 0, dones, 1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        go0 = 1'b0; pause0 = 1'b0; layer_done0 = 1'b0;
        go2 = 1'b0; pause2 = 1'b0; layer_done2 = 1'b0;

        tbl[0] = '{1'b1, -1,  0, 1'b0, 1'b0,  5, 1, 0,  6};
        tbl[1] = '{1'b0, 100, 10, 1'b1, 1'b0,  5, 1, 0,  6};
        tbl[2] = '{1'b0, -1,  0, 1'b0, 1'b1, 49, 1, 0, 50};
        tbl[3] = '{1'b0, -1,  0, 1'b1, 1'b0, -1, 0, 1, 50};
        tbl[4] = '{1'b0, int'($urandom_range(10, 1000)), int'($urandom_range(1, 8)), 1'b0, 1'b0, 1, 1, 0, 2};
        tbl[5] = '{1'b0, -1,  0, 1'b0, 1'b1,  3, 1, 0,  4};

        #12;
        check("reset_outputs", 0,
              int'({rd_en0, rd_addr0, net_start0, net_valid0, net_pixel0, busy0, done0, te0}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i], i, (i == 0) ? 0 : tbl[i-1].exp_te);

        // layer_done while idle must not start or complete anything
        @(posedge clk); #1;
        layer_done0 = 1'b1;
        @(posedge clk); #1;
        layer_done0 = 1'b0;
        @(negedge clk);
        check("idle_ld_busy", 0, int'(busy0), 0);
        check("idle_ld_done", 0, int'(done0), 0);

        run_gap_frame();

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < NPIX; i++) mem0[i] = pixel_t'($urandom);
        @(posedge clk); #1;
        go0 = 1'b1;
        @(posedge clk); #1;
        go0 = 1'b0;
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (rd_en0 && rd_addr0 == 10'd500) break;
        end
        check("reached_pixel_500", 0, int'(k < 2000), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 0,
              int'({rd_en0, rd_addr0, net_start0, net_valid0, net_pixel0, busy0, done0, te0}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(tbl[0], 6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
